// File: rtl/datamover_package.sv
// Shared types for the datamover control path: streamer control/flag
// bundles, the FSM state encoding and the latched job configuration.
package datamover_package;

    // Address generator programming for one streamer job.
    typedef struct packed {
        logic [31:0] base_addr;
        logic [31:0] tot_len;
        logic [31:0] d0_len;
        logic [31:0] d0_stride;
        logic [31:0] d1_len;
        logic [31:0] d1_stride;
        logic [31:0] d2_stride;
        logic [2:0]  dim_enable_1h;
    } hwpe_addressgen_ctrl_t;

    typedef struct packed {
        logic                  req_start;
        hwpe_addressgen_ctrl_t addressgen_ctrl;
    } ctrl_sourcesink_t;

    typedef struct packed {
        logic ready_start;
        logic done;
    } flags_sourcesink_t;

    typedef struct packed {
        ctrl_sourcesink_t data_in_source_ctrl;
        ctrl_sourcesink_t data_out_sink_ctrl;
    } ctrl_streamer_t;

    typedef struct packed {
        flags_sourcesink_t data_in_source_flags;
        flags_sourcesink_t data_out_sink_flags;
        logic              tcdm_fifo_empty;
    } flags_streamer_t;

    typedef enum logic [2:0] {
        DM_IDLE      = 3'd0,
        DM_PROGRAM   = 3'd1,
        DM_WORKING   = 3'd2,
        DM_WAIT_FIFO = 3'd3,
        DM_FINISHED  = 3'd4
    } datamover_state_t;

    // Job configuration. While a job runs, in_addr/out_addr act as the
    // advancing tile pointers and len as the remaining word count. The tile
    // field is stored zero-extended so the chunk compare is a plain 32-bit one.
    typedef struct packed {
        logic [31:0] in_addr;
        logic [31:0] out_addr;
        logic [31:0] len;
        logic [31:0] tile;
    } datamover_cfg_t;

endpackage

// File: rtl/datamover_fsm.sv
// Datamover control FSM: splits a programmed job into tile-sized streamer
// jobs, waits for both streamers and the TCDM FIFO, then pulses done_o.
// Optional feature: define DATAMOVER_PERF_CNT_EN to get a busy-cycle counter
// on perf_cycles_o (tied to 0 otherwise).
module datamover_fsm
    import datamover_package::*;
#(
    parameter int unsigned BW     = 128,
    parameter int unsigned TILE_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic [31:0]         cfg_in_addr_i,
    input  logic [31:0]         cfg_out_addr_i,
    input  logic [31:0]         cfg_len_i,
    input  logic [TILE_W-1:0]   cfg_tile_i,
    output ctrl_streamer_t      ctrl_streamer_o,
    input  flags_streamer_t     flags_streamer_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [31:0]         perf_cycles_o
);

    localparam logic [31:0] WORD_BYTES = 32'(BW / 8);

    datamover_state_t      state_q, state_d;
    datamover_cfg_t        job_q;
    logic                  src_done_q, snk_done_q;
    logic [31:0]           chunk;
    logic [31:0]           remaining_nxt;
    logic                  accept;
    logic                  both_ready;
    logic                  src_done_set, snk_done_set;
    logic                  tile_done;
    hwpe_addressgen_ctrl_t src_ag, snk_ag;

    // Tile size of the current streamer job: whole remainder when tiling is
    // off (tile 0) or when less than one tile is left.
    assign chunk = (job_q.tile == 32'd0 || job_q.len < job_q.tile) ? job_q.len : job_q.tile;
    assign remaining_nxt = job_q.len - chunk;

    assign accept       = (state_q == DM_IDLE) && start_i;
    assign both_ready   = flags_streamer_i.data_in_source_flags.ready_start
                       && flags_streamer_i.data_out_sink_flags.ready_start;
    assign src_done_set = src_done_q || flags_streamer_i.data_in_source_flags.done;
    assign snk_done_set = snk_done_q || flags_streamer_i.data_out_sink_flags.done;
    // Both streamers finished (in either order, or together) this tile.
    assign tile_done    = (state_q == DM_WORKING) && src_done_set && snk_done_set;

    // Address generator programming, 1-D linear walk from the current pointers.
    always_comb begin
        src_ag           = '0;
        snk_ag           = '0;
        src_ag.base_addr = job_q.in_addr;
        src_ag.tot_len   = chunk;
        src_ag.d0_len    = chunk;
        src_ag.d0_stride = WORD_BYTES;
        snk_ag.base_addr = job_q.out_addr;
        snk_ag.tot_len   = chunk;
        snk_ag.d0_len    = chunk;
        snk_ag.d0_stride = WORD_BYTES;
    end

    // State register; clear_i behaves like reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DM_IDLE;
        end else if (clear_i) begin
            state_q <= DM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; req_start additionally waits on ready_start.
    always_comb begin
        state_d         = state_q;
        ctrl_streamer_o = '0;
        busy_o          = (state_q != DM_IDLE);
        done_o          = 1'b0;
        unique case (state_q)
            DM_IDLE: begin
                if (start_i) begin
                    state_d = (cfg_len_i != 32'd0) ? DM_PROGRAM : DM_FINISHED;
                end
            end
            DM_PROGRAM: begin
                ctrl_streamer_o.data_in_source_ctrl.addressgen_ctrl = src_ag;
                ctrl_streamer_o.data_out_sink_ctrl.addressgen_ctrl  = snk_ag;
                if (both_ready) begin
                    ctrl_streamer_o.data_in_source_ctrl.req_start = 1'b1;
                    ctrl_streamer_o.data_out_sink_ctrl.req_start  = 1'b1;
                    state_d = DM_WORKING;
                end
            end
            DM_WORKING: begin
                ctrl_streamer_o.data_in_source_ctrl.addressgen_ctrl = src_ag;
                ctrl_streamer_o.data_out_sink_ctrl.addressgen_ctrl  = snk_ag;
                if (tile_done) begin
                    state_d = (remaining_nxt == 32'd0) ? DM_WAIT_FIFO : DM_PROGRAM;
                end
            end
            DM_WAIT_FIFO: begin
                if (flags_streamer_i.tcdm_fifo_empty) begin
                    state_d = DM_FINISHED;
                end
            end
            DM_FINISHED: begin
                done_o  = 1'b1;
                state_d = DM_IDLE;
            end
            default: begin
                state_d = DM_IDLE;
            end
        endcase
    end

    // Job pointers and remaining count: load on accept, advance per finished tile.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            job_q <= '0;
        end else if (clear_i) begin
            job_q <= '0;
        end else if (accept) begin
            job_q.in_addr  <= cfg_in_addr_i;
            job_q.out_addr <= cfg_out_addr_i;
            job_q.len      <= cfg_len_i;
            job_q.tile     <= 32'(cfg_tile_i);
        end else if (tile_done) begin
            job_q.in_addr  <= job_q.in_addr + chunk * WORD_BYTES;
            job_q.out_addr <= job_q.out_addr + chunk * WORD_BYTES;
            job_q.len      <= remaining_nxt;
        end
    end

    // Sticky per-streamer done flags, only meaningful while WORKING.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_done_q <= 1'b0;
            snk_done_q <= 1'b0;
        end else if (clear_i || state_q != DM_WORKING || tile_done) begin
            src_done_q <= 1'b0;
            snk_done_q <= 1'b0;
        end else begin
            src_done_q <= src_done_set;
            snk_done_q <= snk_done_set;
        end
    end

`ifdef DATAMOVER_PERF_CNT_EN
    logic [31:0] perf_q;

    // Busy-cycle counter: restarts on each accepted job, holds while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (clear_i || accept) begin
            perf_q <= '0;
        end else if (busy_o) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_datamover_fsm.sv
// Self-checking bench for datamover_fsm: a transaction-level model (tile list
// computed up front) predicts every output each cycle, plus literal checks.
module tb_datamover_fsm;
    import datamover_package::*;

    localparam int unsigned BW     = 128;
    localparam int unsigned TILE_W = 16;
    localparam logic [31:0] WB     = 32'(BW / 8);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                clear = 1'b0;
    logic                start = 1'b0;
    logic [31:0]         cin = '0, cout = '0, clen = '0;
    logic [TILE_W-1:0]   ctile = '0;
    ctrl_streamer_t      ctrl;
    flags_streamer_t     flags = '0;
    logic                busy, done;
    logic [31:0]         perf;

    always #5 clk = ~clk;

    datamover_fsm #(.BW(BW), .TILE_W(TILE_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
        .cfg_in_addr_i(cin), .cfg_out_addr_i(cout), .cfg_len_i(clen),
        .cfg_tile_i(ctile), .ctrl_streamer_o(ctrl), .flags_streamer_i(flags),
        .busy_o(busy), .done_o(done), .perf_cycles_o(perf)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] ia; logic [31:0] oa; logic [31:0] len; } tile_t;
    tile_t tiles[$];
    tile_t obs[$];
    bit    m_busy, m_issue, m_wait, m_drain, m_fin, m_sg, m_kg;
    int    m_idx;
    logic [31:0] m_perf = '0;
    int    done_cnt = 0, done_cyc = 0, accept_cyc = 0, last_done_cyc = 0;

    // streamer emulation
    int src_cnt = 0, snk_cnt = 0;
    int d_src = 0, d_snk = 0;     // 0 selects a random delay
    bit rdy_rand = 1'b0;
    int fifo_hold = 0, fifo_cnt = 0;

    task automatic build_tiles(input logic [31:0] ia, input logic [31:0] oa,
                               input logic [31:0] len, input logic [31:0] t);
        logic [31:0] c;
        tiles.delete();
        while (len != 0) begin
            c = (t == 0 || t > len) ? len : t;
            tiles.push_back('{ia, oa, c});
            ia  = ia + c * WB;
            oa  = oa + c * WB;
            len = len - c;
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_issue = 0; m_wait = 0; m_drain = 0; m_fin = 0;
        m_sg = 0; m_kg = 0; m_idx = 0; m_perf = '0; tiles.delete();
    endtask

    // One clock: compare at negedge, advance model, then drive next inputs.
    task automatic tick();
        tile_t cur;
        bit    act, rb;
        @(negedge clk);
        rb  = flags.data_in_source_flags.ready_start && flags.data_out_sink_flags.ready_start;
        act = m_issue || m_wait;
        cur = act ? tiles[m_idx] : '{32'h0, 32'h0, 32'h0};
        chk("busy", {63'd0, busy}, {63'd0, m_busy});
        chk("done", {63'd0, done}, {63'd0, m_fin});
        chk("req_src", {63'd0, ctrl.data_in_source_ctrl.req_start}, {63'd0, m_issue && rb});
        chk("req_snk", {63'd0, ctrl.data_out_sink_ctrl.req_start}, {63'd0, m_issue && rb});
        chk("src_base", {32'd0, ctrl.data_in_source_ctrl.addressgen_ctrl.base_addr}, {32'd0, cur.ia});
        chk("snk_base", {32'd0, ctrl.data_out_sink_ctrl.addressgen_ctrl.base_addr}, {32'd0, cur.oa});
        chk("src_tot", {32'd0, ctrl.data_in_source_ctrl.addressgen_ctrl.tot_len}, {32'd0, cur.len});
        chk("snk_d0len", {32'd0, ctrl.data_out_sink_ctrl.addressgen_ctrl.d0_len}, {32'd0, cur.len});
        chk("src_stride", {32'd0, ctrl.data_in_source_ctrl.addressgen_ctrl.d0_stride},
            {32'd0, act ? WB : 32'd0});
        chk("src_other", {29'd0, ctrl.data_in_source_ctrl.addressgen_ctrl.d1_len,
                          ctrl.data_in_source_ctrl.addressgen_ctrl.dim_enable_1h}, 64'd0);
`ifdef DATAMOVER_PERF_CNT_EN
        chk("perf", {32'd0, perf}, {32'd0, m_perf});
`else
        chk("perf_off", {32'd0, perf}, 64'd0);
`endif
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (ctrl.data_in_source_ctrl.req_start)
            obs.push_back('{ctrl.data_in_source_ctrl.addressgen_ctrl.base_addr,
                            ctrl.data_out_sink_ctrl.addressgen_ctrl.base_addr,
                            ctrl.data_in_source_ctrl.addressgen_ctrl.tot_len});
        if (ctrl.data_in_source_ctrl.req_start) src_cnt = (d_src > 0) ? d_src : $urandom_range(1, 6);
        if (ctrl.data_out_sink_ctrl.req_start)  snk_cnt = (d_snk > 0) ? d_snk : $urandom_range(1, 6);
        // model advance
        if (!rst_n || clear) begin
            model_reset();
        end else begin
            if (!m_busy && start) m_perf = '0;
            else if (m_busy)      m_perf = m_perf + 1;
            if (m_fin) begin
                m_fin = 0; m_busy = 0;
            end else if (!m_busy) begin
                if (start) begin
                    build_tiles(cin, cout, clen, 32'(ctile));
                    accept_cyc = cyc;
                    m_busy = 1; m_idx = 0;
                    if (tiles.size() == 0) m_fin = 1; else m_issue = 1;
                end
            end else if (m_issue) begin
                if (rb) begin m_issue = 0; m_wait = 1; end
            end else if (m_wait) begin
                m_sg = m_sg | flags.data_in_source_flags.done;
                m_kg = m_kg | flags.data_out_sink_flags.done;
                if (m_sg && m_kg) begin
                    m_sg = 0; m_kg = 0; m_wait = 0; m_idx++;
                    if (m_idx == tiles.size()) begin
                        m_drain = 1; last_done_cyc = cyc; fifo_cnt = fifo_hold;
                    end else m_issue = 1;
                end
            end else if (m_drain) begin
                if (flags.tcdm_fifo_empty) begin m_drain = 0; m_fin = 1; end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
        flags.data_in_source_flags.done = 1'b0;
        flags.data_out_sink_flags.done  = 1'b0;
        if (src_cnt > 0) begin src_cnt--; if (src_cnt == 0) flags.data_in_source_flags.done = 1'b1; end
        if (snk_cnt > 0) begin snk_cnt--; if (snk_cnt == 0) flags.data_out_sink_flags.done = 1'b1; end
        flags.data_in_source_flags.ready_start = (src_cnt == 0) && (!rdy_rand || $urandom_range(0, 3) != 0);
        flags.data_out_sink_flags.ready_start  = (snk_cnt == 0) && (!rdy_rand || $urandom_range(0, 3) != 0);
        if (fifo_cnt > 0) begin fifo_cnt--; flags.tcdm_fifo_empty = 1'b0; end
        else flags.tcdm_fifo_empty = 1'b1;
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        do begin tick(); n++; end while (m_busy && n < max);
        if (m_busy) begin
            errors++;
            $display("FAIL timeout_idle cyc=%0d got=busy exp=idle", cyc);
        end
    endtask

    task automatic run_to_wait(input int max);
        int n = 0;
        while (!m_wait && n < max) begin tick(); n++; end
        if (!m_wait) begin
            errors++;
            $display("FAIL timeout_working cyc=%0d got=not_working exp=working", cyc);
        end
    endtask

    task automatic go(input logic [31:0] ia, input logic [31:0] oa,
                      input logic [31:0] len, input logic [TILE_W-1:0] t);
        cin = ia; cout = oa; clen = len; ctile = t; start = 1'b1;
        obs.delete();
    endtask

    initial begin
        int d0;
        flags.tcdm_fifo_empty = 1'b1;
        flags.data_in_source_flags.ready_start = 1'b1;
        flags.data_out_sink_flags.ready_start  = 1'b1;
        model_reset();
        repeat (3) tick();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ctrl", {63'd0, ctrl.data_in_source_ctrl.req_start}, 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // single tile
        d0 = done_cnt;
        go(32'h1000, 32'h2000, 32'd64, '0);
        run_idle(500);
        chk("single_nreq", 64'(obs.size()), 64'd1);
        chk("single_tot", {32'd0, obs[0].len}, 64'd64);
        chk("single_in", {32'd0, obs[0].ia}, 64'h1000);
        chk("single_out", {32'd0, obs[0].oa}, 64'h2000);
        chk("single_done", 64'(done_cnt - d0), 64'd1);
`ifdef DATAMOVER_PERF_CNT_EN
        chk("single_perf_nz", {63'd0, perf != 0}, 64'd1);
`endif

        // tiling 40/16
        d0 = done_cnt;
        go(32'h1000, 32'h3000, 32'd40, 16'd16);
        run_idle(500);
        chk("tile_nreq", 64'(obs.size()), 64'd3);
        chk("tile_len0", {32'd0, obs[0].len}, 64'd16);
        chk("tile_len1", {32'd0, obs[1].len}, 64'd16);
        chk("tile_len2", {32'd0, obs[2].len}, 64'd8);
        chk("tile_in1", {32'd0, obs[1].ia}, 64'h1100);
        chk("tile_in2", {32'd0, obs[2].ia}, 64'h1200);
        chk("tile_done", 64'(done_cnt - d0), 64'd1);

        // skewed done: sink late, source late, together
        for (int k = 0; k < 3; k++) begin
            d_src = (k == 1) ? 8 : 3;
            d_snk = (k == 0) ? 8 : 3;
            go(32'h4000, 32'h5000, 32'd32, 16'd16);
            run_idle(500);
            chk("skew_nreq", 64'(obs.size()), 64'd2);
        end
        d_src = 0; d_snk = 0;

        // zero length
        d0 = done_cnt;
        go(32'h0, 32'h0, 32'd0, '0);
        run_idle(50);
        chk("zero_done_lat", 64'(done_cyc - accept_cyc), 64'd1);
        chk("zero_nreq", 64'(obs.size()), 64'd0);
        chk("zero_done", 64'(done_cnt - d0), 64'd1);

        // start while busy is ignored
        go(32'h8000, 32'h9000, 32'd48, 16'd16);
        run_to_wait(200);
        cin = 32'hDEAD_0000; cout = 32'hBEEF_0000; clen = 32'd5; ctile = 16'd1; start = 1'b1;
        run_idle(500);
        chk("busy_start_nreq", 64'(obs.size()), 64'd3);
        chk("busy_start_in1", {32'd0, obs[1].ia}, 64'h8100);
        chk("busy_start_out2", {32'd0, obs[2].oa}, 64'h9200);

        // FIFO drain delay
        fifo_hold = 10;
        go(32'h100, 32'h200, 32'd16, '0);
        run_idle(500);
        chk("fifo_delay", 64'(done_cyc - last_done_cyc), 64'd12);
        fifo_hold = 0;
        go(32'h100, 32'h200, 32'd16, '0);
        run_idle(500);
        chk("fifo_nodelay", 64'(done_cyc - last_done_cyc), 64'd2);

        // clear while WORKING
        d0 = done_cnt;
        go(32'h100, 32'h200, 32'd64, 16'd8);
        run_to_wait(200);
        clear = 1'b1;
        tick();
        chk("clear_idle", {63'd0, busy}, 64'd0);
        repeat (20) tick();
        chk("clear_nodone", 64'(done_cnt - d0), 64'd0);

        // randomized jobs
        rdy_rand = 1'b1;
        for (int j = 0; j < 25; j++) begin
            fifo_hold = $urandom_range(0, 4);
            go($urandom(), $urandom(), 32'($urandom_range(0, 50)), TILE_W'($urandom_range(0, 12)));
            repeat ($urandom_range(0, 25)) tick();
            if (m_busy && $urandom_range(0, 5) == 0) clear = 1'b1;
            else if (m_busy && $urandom_range(0, 3) == 0) begin
                cin = $urandom(); clen = 32'd3; start = 1'b1;
            end
            run_idle(5000);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
